// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding and operand signedness decode.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iterative_unit_div_restoring_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits, producing one quotient bit.
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] trial;

  // rem < divisor always holds, so a successful subtraction fits in XLEN bits
  assign shifted  = {rem, dividend_bit};
  assign trial    = shifted[XLEN-1:0] - divisor;
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? trial : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_iterative_unit.sv
// Multi-cycle RV32M execute unit: radix-2^MUL_STEP shift-add multiplier and
// restoring divider on magnitudes, with sign fix-up and valid/ready handshakes.
module muldiv_iterative_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int PP_W  = XLEN + MUL_STEP;
  localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(XLEN / MUL_STEP);
  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  XMIN      = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [TAG_W-1:0]  tag_q;

  logic            sa, sb, div_zero, div_ovf, special, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    sa          = is_signed_a(in_op) & in_rs1[XLEN-1];
    sb          = is_signed_b(in_op) & in_rs2[XLEN-1];
    a_mag       = sa ? -in_rs1 : in_rs1;
    b_mag       = sb ? -in_rs2 : in_rs2;
    div_zero    = (in_rs2 == '0);
    div_ovf     = is_signed_b(in_op) & in_op[2] & (in_rs1 == XMIN) & (in_rs2 == '1);
    special     = in_op[2] & (div_zero | div_ovf);
    special_res = div_zero ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : XMIN);
    neg_in      = (in_op == OP_REM) ? sa : (sa ^ sb);
  end

  // Multiply: acc high half accumulates, low half holds the unconsumed multiplier
  logic [PP_W-1:0]   mul_pp, mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fix;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_pp   = PP_W'(opnd) * PP_W'(acc[MUL_STEP-1:0]);
    mul_sum  = PP_W'(acc[2*XLEN-1:XLEN]) + mul_pp;
    mul_next = {mul_sum, acc[XLEN-1:MUL_STEP]};
    mul_fix  = neg_q ? -mul_next : mul_next;
    mul_res  = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
  end

  // Divide: acc high half is the partial remainder, low half shifts dividend out and quotient in
  logic [XLEN-1:0] div_rem, div_quo, div_res;
  logic            div_q;

  div_restoring_step #(.XLEN(XLEN)) u_div_step (
    .rem          (acc[2*XLEN-1:XLEN]),
    .divisor      (opnd),
    .dividend_bit (acc[XLEN-1]),
    .rem_next     (div_rem),
    .q_bit        (div_q)
  );

  always_comb begin
    div_quo = {acc[XLEN-2:0], div_q};
    if (op_q[1])
      div_res = neg_q ? -div_rem : div_rem;
    else
      div_res = neg_q ? -div_quo : div_quo;
  end

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      busy       <= 1'b0;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      tag_q      <= '0;
    end else if (flush) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_MUL: begin
          acc <= mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            out_result <= mul_res;
            out_tag    <= tag_q;
          end
        end
        ST_DIV: begin
          acc <= {div_rem, div_quo};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            out_result <= div_res;
            out_tag    <= tag_q;
          end
        end
        default: begin
          if (in_valid && in_ready) begin
            op_q  <= in_op;
            neg_q <= neg_in;
            tag_q <= in_tag;
            if (special) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              out_valid  <= 1'b1;
              out_result <= special_res;
              out_tag    <= in_tag;
            end else begin
              state     <= in_op[2] ? ST_DIV : ST_MUL;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              cnt       <= in_op[2] ? DIV_ITERS : MUL_ITERS;
              opnd      <= in_op[2] ? b_mag : a_mag;
              acc       <= {{XLEN{1'b0}}, (in_op[2] ? a_mag : b_mag)};
            end
          end else if (state == ST_DONE && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
